// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: one move handshake per round, LFSR or
// forced computer move, scoring up to ROUNDS_TO_WIN round wins.
module rps_match_ctrl #(
    parameter int unsigned ROUNDS_TO_WIN = 3,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       move_valid,
    input  logic [1:0] player_move,
    input  logic       cpu_force_en,
    input  logic [1:0] cpu_force_move,
    output logic       move_ready,
    output logic [1:0] computer_move,
    output logic       result_valid,
    output logic [1:0] result,
    output logic [3:0] player_score,
    output logic [3:0] computer_score,
    output logic       match_done,
    output logic       match_winner
);

    typedef enum logic [2:0] {IDLE, WAIT_MOVE, RESOLVE, REPORT, DONE} state_t;

    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [3:0] WIN  = 4'(ROUNDS_TO_WIN);

    state_t     state;
    logic [7:0] lfsr;
    logic [1:0] pm_q;
    logic [1:0] cm_q;
    logic       lfsr_fb;
    logic [1:0] lfsr_move;
    logic [1:0] round_res;

    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lfsr_move = (lfsr[1:0] == 2'b11) ? 2'b00 : lfsr[1:0];

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b00 && b == 2'b10) ||
               (a == 2'b01 && b == 2'b00) ||
               (a == 2'b10 && b == 2'b01);
    endfunction

    always_comb begin
        round_res = 2'b00;
        if (pm_q == 2'b11)
            round_res = 2'b11;
        else if (beats(pm_q, cm_q))
            round_res = 2'b01;
        else if (beats(cm_q, pm_q))
            round_res = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lfsr           <= SEED;
            pm_q           <= '0;
            cm_q           <= '0;
            move_ready     <= 1'b0;
            computer_move  <= '0;
            result_valid   <= 1'b0;
            result         <= '0;
            player_score   <= '0;
            computer_score <= '0;
            match_done     <= 1'b0;
            match_winner   <= 1'b0;
        end else begin
            lfsr         <= {lfsr[6:0], lfsr_fb};
            result_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // start has priority; move_ready is 0 here so no move is taken
                    if (start) begin
                        player_score   <= '0;
                        computer_score <= '0;
                        result         <= '0;
                        computer_move  <= '0;
                        match_done     <= 1'b0;
                        match_winner   <= 1'b0;
                        move_ready     <= 1'b1;
                        state          <= WAIT_MOVE;
                    end
                end
                WAIT_MOVE: begin
                    if (move_valid && move_ready) begin
                        pm_q       <= player_move;
                        cm_q       <= cpu_force_en ? cpu_force_move : lfsr_move;
                        move_ready <= 1'b0;
                        state      <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    result        <= round_res;
                    computer_move <= cm_q;
                    result_valid  <= 1'b1;
                    if (round_res == 2'b01 && player_score != WIN)
                        player_score <= player_score + 4'd1;
                    if (round_res == 2'b10 && computer_score != WIN)
                        computer_score <= computer_score + 4'd1;
                    state <= REPORT;
                end
                REPORT: begin
                    if (player_score == WIN || computer_score == WIN) begin
                        match_done   <= 1'b1;
                        match_winner <= (player_score == WIN);
                        state        <= DONE;
                    end else begin
                        move_ready <= 1'b1;
                        state      <= WAIT_MOVE;
                    end
                end
                default: begin
                    move_ready <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed self-checking bench for rps_match_ctrl with a reference LFSR model.
module tb_rps_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] player_move = 2'b00;
    logic       cpu_force_en = 1'b0;
    logic [1:0] cpu_force_move = 2'b00;
    logic       move_ready;
    logic [1:0] computer_move;
    logic       result_valid;
    logic [1:0] result;
    logic [3:0] player_score;
    logic [3:0] computer_score;
    logic       match_done;
    logic       match_winner;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_lfsr;

    rps_match_ctrl #(.ROUNDS_TO_WIN(3), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
        .player_move(player_move), .cpu_force_en(cpu_force_en),
        .cpu_force_move(cpu_force_move), .move_ready(move_ready),
        .computer_move(computer_move), .result_valid(result_valid),
        .result(result), .player_score(player_score),
        .computer_score(computer_score), .match_done(match_done),
        .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_lfsr <= 8'hA5;
        else        ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] ref_result(input logic [1:0] p, input logic [1:0] c);
        if (p == 2'b11) return 2'b11;
        if ((p == 2'd0 && c == 2'd2) || (p == 2'd1 && c == 2'd0) || (p == 2'd2 && c == 2'd1)) return 2'b01;
        if ((c == 2'd0 && p == 2'd2) || (c == 2'd1 && p == 2'd0) || (c == 2'd2 && p == 2'd1)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Plays one round from WAIT_MOVE; returns the REPORT-cycle outputs and whether the
    // handshake/latency sequence (ready, N+1 quiet, N+2 pulse, N+3 pulse gone) held.
    task automatic do_round(input logic [1:0] pm, input logic fe, input logic [1:0] fm,
                            output logic [1:0] r, output logic [1:0] cm,
                            output logic [3:0] ps, output logic [3:0] cs,
                            output logic [1:0] exp_rand, output logic seq_ok);
        int unsigned n;
        n = 0;
        seq_ok = 1'b1;
        while (move_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (move_ready !== 1'b1) seq_ok = 1'b0;
        move_valid = 1'b1;
        player_move = pm;
        cpu_force_en = fe;
        cpu_force_move = fm;
        exp_rand = (ref_lfsr[1:0] == 2'b11) ? 2'b00 : ref_lfsr[1:0];
        tick();
        move_valid = 1'b0;
        if (move_ready !== 1'b0 || result_valid !== 1'b0) seq_ok = 1'b0;
        tick();
        if (result_valid !== 1'b1 || move_ready !== 1'b0) seq_ok = 1'b0;
        r = result;
        cm = computer_move;
        ps = player_score;
        cs = computer_score;
        tick();
        if (result_valid !== 1'b0) seq_ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] o;
        rst_n = 1'b0;
        #23;
        o = {move_ready, computer_move, result_valid, result, player_score, computer_score, match_done, match_winner};
        checks++;
        if (o !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0000", o);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (move_ready !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got ready=%b valid=%b required 0 0", move_ready, result_valid);
        end
    endtask

    task automatic test_rounds();
        logic [1:0] r, cm, er;
        logic [3:0] ps, cs;
        logic ok;
        pulse_start();
        checks++;
        if (move_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: got %b required 1", move_ready);
        end
        do_round(2'b01, 1'b1, 2'b01, r, cm, ps, cs, er, ok);
        checks++;
        if (!ok || r !== 2'b00 || cm !== 2'b01 || ps !== 4'd0 || cs !== 4'd0) begin
            errors++;
            $display("FAIL tie: got ok=%b r=%b cm=%b %0d:%0d required 1 00 01 0:0", ok, r, cm, ps, cs);
        end
        do_round(2'b11, 1'b1, 2'b00, r, cm, ps, cs, er, ok);
        checks++;
        if (!ok || r !== 2'b11 || ps !== 4'd0 || cs !== 4'd0) begin
            errors++;
            $display("FAIL illegal: got ok=%b r=%b %0d:%0d required 1 11 0:0", ok, r, ps, cs);
        end
        do_round(2'b00, 1'b1, 2'b10, r, cm, ps, cs, er, ok);
        checks++;
        if (!ok || r !== 2'b01 || cm !== 2'b10 || ps !== 4'd1 || cs !== 4'd0) begin
            errors++;
            $display("FAIL rock_vs_scissors: got ok=%b r=%b cm=%b %0d:%0d required 1 01 10 1:0", ok, r, cm, ps, cs);
        end
        do_round(2'b01, 1'b1, 2'b00, r, cm, ps, cs, er, ok);
        checks++;
        if (!ok || r !== 2'b01 || cm !== 2'b00 || ps !== 4'd2 || cs !== 4'd0) begin
            errors++;
            $display("FAIL paper_vs_rock: got ok=%b r=%b cm=%b %0d:%0d required 1 01 00 2:0", ok, r, cm, ps, cs);
        end
        checks++;
        if (move_ready !== 1'b1) begin
            errors++;
            $display("FAIL next_ready: got %b required 1", move_ready);
        end
    endtask

    task automatic test_start_ignored_and_reset();
        logic [1:0] r, cm, er;
        logic [3:0] ps, cs;
        logic ok;
        logic [15:0] o;
        logic bad;
        pulse_start();
        checks++;
        if (player_score !== 4'd2 || computer_score !== 4'd0 || move_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_in_wait: got %0d:%0d ready=%b required 2:0 1", player_score, computer_score, move_ready);
        end
        do_round(2'b00, 1'b1, 2'b01, r, cm, ps, cs, er, ok);
        checks++;
        if (!ok || r !== 2'b10 || cm !== 2'b01 || ps !== 4'd2 || cs !== 4'd1) begin
            errors++;
            $display("FAIL rock_vs_paper: got ok=%b r=%b cm=%b %0d:%0d required 1 10 01 2:1", ok, r, cm, ps, cs);
        end
        move_valid = 1'b1;
        player_move = 2'b00;
        cpu_force_move = 2'b10;
        tick();
        move_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        o = {move_ready, computer_move, result_valid, result, player_score, computer_score, match_done, match_winner};
        checks++;
        if (o !== 16'h0) begin
            errors++;
            $display("FAIL reset_in_resolve: got %h required 0000", o);
        end
        #2;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (result_valid !== 1'b0 || move_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_quiet: got a valid/ready pulse required none");
        end
    endtask

    task automatic test_match_player();
        logic [1:0] r, cm, er;
        logic [3:0] ps, cs;
        logic ok;
        logic bad;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            do_round(2'b00, 1'b1, 2'b01, r, cm, ps, cs, er, ok);
            checks++;
            if (!ok || r !== 2'b10 || cs !== 4'(i + 1) || ps !== 4'd0) begin
                errors++;
                $display("FAIL cpu_round%0d: got ok=%b r=%b %0d:%0d required 1 10 0:%0d", i, ok, r, ps, cs, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_round(2'b00, 1'b1, 2'b10, r, cm, ps, cs, er, ok);
            checks++;
            if (!ok || r !== 2'b01 || ps !== 4'(i + 1) || cs !== 4'd2) begin
                errors++;
                $display("FAIL player_round%0d: got ok=%b r=%b %0d:%0d required 1 01 %0d:2", i, ok, r, ps, cs, i + 1);
            end
        end
        checks++;
        if (match_done !== 1'b1 || match_winner !== 1'b1 || move_ready !== 1'b0 ||
            player_score !== 4'd3 || computer_score !== 4'd2) begin
            errors++;
            $display("FAIL match_done_player: got done=%b win=%b ready=%b %0d:%0d required 1 1 0 3:2",
                     match_done, match_winner, move_ready, player_score, computer_score);
        end
        move_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (move_ready !== 1'b0 || result_valid !== 1'b0 || player_score !== 4'd3 || match_done !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL done_ignores_move: got activity in DONE required none");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        move_valid = 1'b0;
        checks++;
        if (move_ready !== 1'b1 || player_score !== 4'd0 || computer_score !== 4'd0 ||
            match_done !== 1'b0 || match_winner !== 1'b0 || result !== 2'b00) begin
            errors++;
            $display("FAIL restart: got ready=%b %0d:%0d done=%b win=%b r=%b required 1 0:0 0 0 00",
                     move_ready, player_score, computer_score, match_done, match_winner, result);
        end
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_beats_move: got valid=%b required 0", result_valid);
        end
    endtask

    task automatic test_match_cpu();
        logic [1:0] r, cm, er;
        logic [3:0] ps, cs;
        logic ok;
        for (int i = 0; i < 3; i++) do_round(2'b10, 1'b1, 2'b00, r, cm, ps, cs, er, ok);
        checks++;
        if (!ok || match_done !== 1'b1 || match_winner !== 1'b0 || computer_score !== 4'd3 || player_score !== 4'd0) begin
            errors++;
            $display("FAIL match_done_cpu: got ok=%b done=%b win=%b %0d:%0d required 1 1 0 0:3",
                     ok, match_done, match_winner, player_score, computer_score);
        end
        pulse_start();
    endtask

    task automatic test_lfsr();
        logic [1:0] r, cm, er;
        logic [3:0] ps, cs;
        logic ok;
        for (int i = 0; i < 20; i++) begin
            do_round(2'b00, 1'b0, 2'b11, r, cm, ps, cs, er, ok);
            checks++;
            if (!ok || cm === 2'b11 || cm !== er || r !== ref_result(2'b00, er) || ps > 4'd3 || cs > 4'd3) begin
                errors++;
                $display("FAIL lfsr_round%0d: got ok=%b cm=%b r=%b %0d:%0d required cm=%b r=%b",
                         i, ok, cm, r, ps, cs, er, ref_result(2'b00, er));
            end
            if (match_done === 1'b1) pulse_start();
        end
    endtask

    initial begin
        test_reset();
        test_rounds();
        test_start_ignored_and_reset();
        test_match_player();
        test_match_cpu();
        test_lfsr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
